mhp_tx: RTL

Frame transmitter for the MHP byte protocol. It serializes one MHP frame onto the Ethernet byte-write interface: destination, source, size, type, payload and a computed checksum. It sits between the board-side command logic, which supplies the header fields and a payload byte stream, and the Ethernet write port. It is the sending counterpart of the MHP frame parser.

---
 rtl/mhp_tx_if.sv | 26 ++
 rtl/mhp_tx.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mhp_tx_if.sv
// rtl/mhp_tx_if.sv - payload-in and Ethernet-write byte streams of the MHP transmitter
//
// Purpose: bundles the two byte handshakes of mhp_tx.
//   i_pdata/i_pvalid/o_pready : payload byte stream into the transmitter
//   o_wdata/o_wvalid/i_wready : serialized frame bytes out to the Ethernet write port
// Modports:
//   master : the transmitter side (drives o_pready, o_wdata, o_wvalid)
//   slave  : the environment side (drives i_pdata, i_pvalid, i_wready)
interface mhp_tx_if;
  logic [7:0] i_pdata;
  logic       i_pvalid;
  logic       o_pready;
  logic [7:0] o_wdata;
  logic       o_wvalid;
  logic       i_wready;

  modport master (
    input  i_pdata, i_pvalid, i_wready,
    output o_pready, o_wdata, o_wvalid
  );

  modport slave (
    output i_pdata, i_pvalid, i_wready,
    input  o_pready, o_wdata, o_wvalid
  );
endinterface

// File: rtl/mhp_tx.sv
// rtl/mhp_tx.sv - MHP frame transmitter (header, payload, 16-bit checksum)
//
// Purpose: serializes one MHP frame per accepted i_start onto the Ethernet
// byte-write stream: dst(2) src(2) size(2) dtype(1) payload(size) csum(2).
// csum is the 16-bit wrap-around sum of all preceding frame bytes.
// Ports:
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_start             : one-cycle send request, header inputs sampled with it
//   i_dst, i_src        : 16-bit MHP addresses
//   i_size              : payload length in bytes (rejected above MAX_SIZE)
//   i_dtype             : MHP type byte
//   bus (master)        : payload stream in, frame byte stream out
//   o_busy              : frame in progress (first byte through last accept)
//   o_done              : one-cycle pulse after the last byte is accepted
//   o_err               : one-cycle pulse after a rejected request
module mhp_tx #(
  parameter int MAX_SIZE = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [15:0] i_dst,
  input  logic [15:0] i_src,
  input  logic [15:0] i_size,
  input  logic [7:0]  i_dtype,
  mhp_tx_if.master    bus,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  localparam logic [15:0] MAX_SZ = 16'(MAX_SIZE);

  typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, CSUM, DONE} state_t;

  state_t      state;
  logic [2:0]  hdr_idx;
  logic        csum_idx;
  logic        csum_last;   // low checksum byte is loaded, waiting for its accept
  logic [15:0] remain;
  logic [15:0] acc;
  logic [15:0] dst_q;
  logic [15:0] src_q;
  logic [15:0] size_q;
  logic [7:0]  dtype_q;
  logic [7:0]  wdata_q;
  logic        wvalid_q;

  logic        load_opp;
  logic        p_take;
  logic [7:0]  hdr_byte;

  // The output register can take a new byte when empty or being drained.
  assign load_opp     = !wvalid_q || bus.i_wready;
  assign bus.o_pready = (state == PAYLOAD) && load_opp && (remain != 16'd0);
  assign p_take       = bus.o_pready && bus.i_pvalid;
  assign bus.o_wdata  = wdata_q;
  assign bus.o_wvalid = wvalid_q;

  always_comb begin
    hdr_byte = 8'h00;
    case (hdr_idx)
      3'd0:    hdr_byte = dst_q[15:8];
      3'd1:    hdr_byte = dst_q[7:0];
      3'd2:    hdr_byte = src_q[15:8];
      3'd3:    hdr_byte = src_q[7:0];
      3'd4:    hdr_byte = size_q[15:8];
      3'd5:    hdr_byte = size_q[7:0];
      3'd6:    hdr_byte = dtype_q;
      default: hdr_byte = 8'h00;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      hdr_idx   <= 3'd0;
      csum_idx  <= 1'b0;
      csum_last <= 1'b0;
      remain    <= 16'd0;
      acc       <= 16'd0;
      dst_q     <= 16'd0;
      src_q     <= 16'd0;
      size_q    <= 16'd0;
      dtype_q   <= 8'd0;
      wdata_q   <= 8'd0;
      wvalid_q  <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      // Empty the register at any load opportunity; a load below overrides.
      if (load_opp) wvalid_q <= 1'b0;

      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (i_start) begin
            if (i_size > MAX_SZ) begin
              o_err <= 1'b1;
            end else begin
              dst_q     <= i_dst;
              src_q     <= i_src;
              size_q    <= i_size;
              dtype_q   <= i_dtype;
              remain    <= i_size;
              // First header byte goes out straight from the inputs so it
              // is on the wire the cycle after i_start.
              wdata_q   <= i_dst[15:8];
              wvalid_q  <= 1'b1;
              acc       <= {8'h00, i_dst[15:8]};
              hdr_idx   <= 3'd1;
              csum_idx  <= 1'b0;
              csum_last <= 1'b0;
              o_busy    <= 1'b1;
              state     <= HDR;
            end
          end
        end

        HDR: begin
          if (load_opp) begin
            wdata_q  <= hdr_byte;
            wvalid_q <= 1'b1;
            acc      <= acc + {8'h00, hdr_byte};
            if (hdr_idx == 3'd6) begin
              state <= (size_q != 16'd0) ? PAYLOAD : CSUM;
            end else begin
              hdr_idx <= hdr_idx + 3'd1;
            end
          end
        end

        PAYLOAD: begin
          if (p_take) begin
            wdata_q  <= bus.i_pdata;
            wvalid_q <= 1'b1;
            acc      <= acc + {8'h00, bus.i_pdata};
            remain   <= remain - 16'd1;
            if (remain == 16'd1) state <= CSUM;
          end
        end

        CSUM: begin
          if (load_opp) begin
            if (csum_last) begin
              // Register was full with the low byte, so this is its accept.
              o_busy <= 1'b0;
              o_done <= 1'b1;
              state  <= DONE;
            end else begin
              // acc is final here: every frame byte was added when loaded.
              wdata_q  <= csum_idx ? acc[7:0] : acc[15:8];
              wvalid_q <= 1'b1;
              if (csum_idx) csum_last <= 1'b1;
              csum_idx <= ~csum_idx;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
